instruction_fetcher: RTL

- Upstream neighbour of the decoder.
- Holds the architectural fetch PC and a direct-mapped instruction cache, and refills that cache from the memory controller on a miss.
- On a cache hit it issues one instruction per cycle to the decoder: instruction word, PC, and a statically predicted next PC.
- Stalls while the dispatcher reports that downstream structures are full. Redirects on a ROB rollback.

---
 rtl/instruction_fetcher.sv | 129 ++++++++++++
 1 files changed

// File: rtl/instruction_fetcher.sv
// Fetch stage: owns the fetch PC and a direct-mapped one-word-per-line I-cache.
// On a hit it issues one instruction per cycle; on a miss it refills from the memory controller.
`timescale 1ns/1ps
module instruction_fetcher #(
    parameter int          ICACHE_INDEX_BITS = 8,
    parameter logic [31:0] RESET_PC          = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        full_in,
    input  logic        rob_rollback_in,
    input  logic [31:0] rob_rollback_pc_in,
    output logic        mc_request_out,
    output logic [31:0] mc_addr_out,
    input  logic        mc_valid_in,
    input  logic [31:0] mc_inst_in,
    output logic        dec_issue_out,
    output logic [31:0] dec_inst_out,
    output logic [31:0] dec_pc_out,
    output logic [31:0] dec_predict_pc_out
);
    localparam int ENTRIES = 1 << ICACHE_INDEX_BITS;
    localparam int TAG_W   = 30 - ICACHE_INDEX_BITS;

    typedef enum logic {IDLE, WAIT_MEM} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:2] miss_line, miss_line_nxt;
    logic        mc_req_nxt, issue_nxt;
    logic [31:0] mc_addr_nxt, inst_nxt, dpc_nxt, pred_nxt;

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tag_ram  [ENTRIES];
    logic [31:0]        data_ram [ENTRIES];

    logic [ICACHE_INDEX_BITS-1:0] idx, fill_idx;
    logic [TAG_W-1:0]             tag, fill_tag;
    logic [31:0]                  word, pred;
    logic                         hit, fill_en;

    assign idx      = pc[ICACHE_INDEX_BITS+1:2];
    assign tag      = pc[31:ICACHE_INDEX_BITS+2];
    assign fill_idx = miss_line[ICACHE_INDEX_BITS+1:2];
    assign fill_tag = miss_line[31:ICACHE_INDEX_BITS+2];
    assign word     = data_ram[idx];
    assign hit      = valid[idx] && (tag_ram[idx] == tag);
    // Fill always targets the recorded miss line, so a redirect mid-refill is harmless.
    assign fill_en  = rdy_in && (state == WAIT_MEM) && mc_valid_in;

    // Static prediction: JAL and backward branches taken, everything else falls through.
    always_comb begin
        pred = pc + 32'd4;
        if (word[6:0] == 7'b1101111)
            pred = pc + {{11{word[31]}}, word[31], word[19:12], word[20], word[30:21], 1'b0};
        else if (word[6:0] == 7'b1100011 && word[31])
            pred = pc + {{19{word[31]}}, word[31], word[7], word[30:25], word[11:8], 1'b0};
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        miss_line_nxt = miss_line;
        mc_req_nxt    = mc_request_out;
        mc_addr_nxt   = mc_addr_out;
        issue_nxt     = 1'b0;
        inst_nxt      = dec_inst_out;
        dpc_nxt       = dec_pc_out;
        pred_nxt      = dec_predict_pc_out;
        if (state == WAIT_MEM && mc_valid_in) begin
            mc_req_nxt = 1'b0;
            state_nxt  = IDLE;
        end
        if (rob_rollback_in) begin
            pc_nxt = rob_rollback_pc_in;
        end else if (state == IDLE) begin
            if (hit) begin
                if (!full_in) begin
                    issue_nxt = 1'b1;
                    inst_nxt  = word;
                    dpc_nxt   = pc;
                    pred_nxt  = pred;
                    pc_nxt    = pred;
                end
            end else begin
                mc_req_nxt    = 1'b1;
                mc_addr_nxt   = {pc[31:2], 2'b00};
                miss_line_nxt = pc[31:2];
                state_nxt     = WAIT_MEM;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state              <= IDLE;
            pc                 <= RESET_PC;
            miss_line          <= '0;
            valid              <= '0;
            mc_request_out     <= 1'b0;
            mc_addr_out        <= '0;
            dec_issue_out      <= 1'b0;
            dec_inst_out       <= '0;
            dec_pc_out         <= '0;
            dec_predict_pc_out <= '0;
        end else if (rdy_in) begin
            state              <= state_nxt;
            pc                 <= pc_nxt;
            miss_line          <= miss_line_nxt;
            mc_request_out     <= mc_req_nxt;
            mc_addr_out        <= mc_addr_nxt;
            dec_issue_out      <= issue_nxt;
            dec_inst_out       <= inst_nxt;
            dec_pc_out         <= dpc_nxt;
            dec_predict_pc_out <= pred_nxt;
            if (fill_en)
                valid[fill_idx] <= 1'b1;
        end
    end

    // Tag/data arrays carry no reset; the valid bits guard them.
    always_ff @(posedge clk_in) begin
        if (fill_en) begin
            tag_ram[fill_idx]  <= fill_tag;
            data_ram[fill_idx] <= mc_inst_in;
        end
    end
endmodule
